rgb_frame_monitor: RTL and testbench
====================================

Name: rgb_frame_monitor

Overview:
- Sink-side monitor on the VGA colour bus driven by the colorizer.
- Samples the registered 12-bit RGB stream plus video_on and vsync, and rebuilds the active-pixel geometry of each frame.
- Per frame it computes a rotating signature and captures one probe pixel.
- Results go to the debug/seven-segment path through a valid/ack handshake, for on-board and simulation checks of displayed frames.

Parameters:
- VSYNC_POL, 0, active level of pVsync (0 = active-low, matches the DTG).
- SIG_W, 16, signature width in bits (minimum 12).

Ports:
- pClk  input  1  pixel clock.
- pReset  input  1  synchronous, active-low reset.
- pRed_VGA  input  4  red nibble.
- pGreen_VGA  input  4  green nibble.
- pBlue_VGA  input  4  blue nibble.
- pVideo_on  input  1  active-video qualifier, time-aligned with RGB.
- pVsync  input  1  vertical sync from the DTG, time-aligned with RGB.
- pProbeX  input  10  probe column.
- pProbeY  input  10  probe row.
- pFrameAck  input  1  consumer acknowledge.
- pFrameValid  output  1  latched frame results available.
- pFrameSig  output  SIG_W  frame signature.
- pPixelCount  output  20  active pixels in frame.
- pLineCount  output  10  active lines in frame.
- pProbePixel  output  12  {R,G,B} at the probe coordinate.
- pProbeHit  output  1  probe coordinate was reached.
- pOverrun  output  1  sticky: a frame was lost while valid was pending.

Behaviour:
- Reset (pReset == 0 at a pClk edge):
  - All outputs go to 0.
  - Working counters and signature clear.
  - FSM goes to SYNC_WAIT.
  - Reset in mid-frame discards the partial frame.
- Pixel word: pix = {pRed_VGA, pGreen_VGA, pBlue_VGA}.
- Vsync edge: vs = (pVsync == VSYNC_POL). The edge fires in a cycle where vs == 1 and the registered vs was 0.
- FSM has two states:
  - SYNC_WAIT: ignore all pixels; on a vsync edge, clear working state and go to CAPTURE.
  - CAPTURE: accumulate. On a vsync edge, commit the frame, clear working state and stay in CAPTURE.
- Accumulation, on each CAPTURE cycle with pVideo_on == 1 and no edge:
  - sig = rotl1(sig) ^ zero-extended pix.
  - pixcnt += 1, saturating at 2^20−1.
  - x += 1, saturating at 1023.
  - If x == pProbeX and y == pProbeY: probe = pix, hit = 1. The last match wins.
- Line end: on a pVideo_on falling edge (registered 1, current 0) in CAPTURE:
  - x is cleared to 0.
  - y and linecnt increment, both saturating at 1023.
- Edge-cycle pixels: a pixel presented in the same cycle as a vsync edge is dropped and not counted.
- Commit: outputs load from the working registers at the clock edge following the vsync-edge cycle (latency 1).
  - If pFrameValid == 0: load outputs, set pFrameValid = 1.
  - If pFrameValid == 1 and pFrameAck == 1 in the commit cycle: load new outputs, pFrameValid stays 1.
  - If pFrameValid == 1 and pFrameAck == 0: outputs are held, the new frame is discarded, pOverrun = 1.
- Handshake:
  - pFrameAck sampled high while pFrameValid == 1 and no commit clears pFrameValid next cycle, and also clears pOverrun.
  - pFrameAck while pFrameValid == 0 is ignored.
  - Output values stay stable while pFrameValid == 1.
- Probe update: pProbeX/pProbeY may change at any time and take effect on the following pixel. pProbePixel = 0 whenever pProbeHit == 0.

Optional Feature:
- Macro: RGB_FRAME_MONITOR_COMPARE_EN.
- When defined:
  - Adds output pFrameChanged (1 bit) and an internal previous-signature register.
  - At each accepted commit, pFrameChanged = (new sig != previous accepted sig), then the previous signature updates.
  - The first commit after reset reports pFrameChanged = 1.
  - pFrameChanged resets to 0.
  - Discarded (overrun) frames do not update the previous signature.
- When undefined: the port and register are absent; the rest of the behaviour is identical.

Test Plan:
- Reset with pReset = 0 while toggling all inputs → all outputs 0. The first vsync edge after release produces no commit; the second produces one.
- Frame of one line with 2 pixels, 12'h00F then 12'h0F0, probe (1,0) → pFrameSig = 16'h00EE, pPixelCount = 2, pLineCount = 1, pProbePixel = 12'h0F0, pProbeHit = 1, pFrameValid rises 1 cycle after the edge.
- Frame of 3 lines × 4 pixels, probe (9,9) → pPixelCount = 12, pLineCount = 3, pProbeHit = 0, pProbePixel = 0.
- Two frames with no ack → the first frame's values are held and pOverrun = 1. Ack → pFrameValid and pOverrun clear next cycle.
- Ack asserted in the same cycle as a commit → new values loaded, pFrameValid stays 1, pOverrun = 0.
- With RGB_FRAME_MONITOR_COMPARE_EN defined, two identical frames then one changed pixel, each acked → pFrameChanged = 1, 0, 1.

Source files
------------

// File: rtl/rgb_frame_monitor.sv
// rgb_frame_monitor: per-frame signature, geometry and probe capture on the VGA colour bus.
// Optional RGB_FRAME_MONITOR_COMPARE_EN adds pFrameChanged (signature differs from last accepted frame).
module rgb_frame_monitor #(
  parameter bit VSYNC_POL = 1'b0,
  parameter int SIG_W     = 16
) (
  input  logic             pClk,
  input  logic             pReset,
  input  logic [3:0]       pRed_VGA,
  input  logic [3:0]       pGreen_VGA,
  input  logic [3:0]       pBlue_VGA,
  input  logic             pVideo_on,
  input  logic             pVsync,
  input  logic [9:0]       pProbeX,
  input  logic [9:0]       pProbeY,
  input  logic             pFrameAck,
  output logic             pFrameValid,
  output logic [SIG_W-1:0] pFrameSig,
  output logic [19:0]      pPixelCount,
  output logic [9:0]       pLineCount,
  output logic [11:0]      pProbePixel,
  output logic             pProbeHit,
  output logic             pOverrun
`ifdef RGB_FRAME_MONITOR_COMPARE_EN
  ,
  output logic             pFrameChanged
`endif
);

  typedef enum logic {SYNC_WAIT, CAPTURE} state_t;

  state_t           state_q, state_d;
  logic             vs_q, vs_d;
  logic             vid_q, vid_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [19:0]      pix_q, pix_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       line_q, line_d;
  logic [11:0]      probe_q, probe_d;
  logic             hit_q, hit_d;

  logic             valid_q, valid_d;
  logic [SIG_W-1:0] osig_q, osig_d;
  logic [19:0]      opix_q, opix_d;
  logic [9:0]       oline_q, oline_d;
  logic [11:0]      oprobe_q, oprobe_d;
  logic             ohit_q, ohit_d;
  logic             ovr_q, ovr_d;
`ifdef RGB_FRAME_MONITOR_COMPARE_EN
  logic [SIG_W-1:0] prev_q, prev_d;
  logic             prev_ok_q, prev_ok_d;
  logic             chg_q, chg_d;
`endif

  logic [11:0] pix;
  logic        vs;
  logic        vs_edge;
  logic        line_end;
  logic        commit;
  logic        load;

  assign pix      = {pRed_VGA, pGreen_VGA, pBlue_VGA};
  assign vs       = (pVsync == VSYNC_POL);
  assign vs_edge  = vs && !vs_q;
  assign line_end = vid_q && !pVideo_on;

  // Working-frame accumulation, frame commit and consumer handshake.
  always_comb begin
    state_d  = state_q;
    vs_d     = vs;
    vid_d    = pVideo_on;
    sig_d    = sig_q;
    pix_d    = pix_q;
    x_d      = x_q;
    line_d   = line_q;
    probe_d  = probe_q;
    hit_d    = hit_q;
    valid_d  = valid_q;
    osig_d   = osig_q;
    opix_d   = opix_q;
    oline_d  = oline_q;
    oprobe_d = oprobe_q;
    ohit_d   = ohit_q;
    ovr_d    = ovr_q;
`ifdef RGB_FRAME_MONITOR_COMPARE_EN
    prev_d    = prev_q;
    prev_ok_d = prev_ok_q;
    chg_d     = chg_q;
`endif
    commit = 1'b0;
    load   = 1'b0;

    if (vs_edge) begin
      commit  = (state_q == CAPTURE);
      state_d = CAPTURE;
      sig_d   = '0;
      pix_d   = '0;
      x_d     = '0;
      line_d  = '0;
      probe_d = '0;
      hit_d   = 1'b0;
    end else if (state_q == CAPTURE) begin
      if (pVideo_on) begin
        sig_d = {sig_q[SIG_W-2:0], sig_q[SIG_W-1]} ^ SIG_W'(pix);
        if (pix_q != '1) pix_d = pix_q + 20'd1;
        if (x_q != '1) x_d = x_q + 10'd1;
        if (x_q == pProbeX && line_q == pProbeY) begin
          probe_d = pix;
          hit_d   = 1'b1;
        end
      end else if (line_end) begin
        x_d = '0;
        if (line_q != '1) line_d = line_q + 10'd1;
      end
    end

    if (commit) begin
      if (!valid_q) begin
        load    = 1'b1;
        valid_d = 1'b1;
      end else if (pFrameAck) begin
        load  = 1'b1;
        ovr_d = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && pFrameAck) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    if (load) begin
      osig_d   = sig_q;
      opix_d   = pix_q;
      oline_d  = line_q;
      oprobe_d = probe_q;
      ohit_d   = hit_q;
`ifdef RGB_FRAME_MONITOR_COMPARE_EN
      chg_d     = !prev_ok_q || (sig_q != prev_q);
      prev_d    = sig_q;
      prev_ok_d = 1'b1;
`endif
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge pClk) begin
    if (!pReset) begin
      state_q  <= SYNC_WAIT;
      vs_q     <= 1'b0;
      vid_q    <= 1'b0;
      sig_q    <= '0;
      pix_q    <= '0;
      x_q      <= '0;
      line_q   <= '0;
      probe_q  <= '0;
      hit_q    <= 1'b0;
      valid_q  <= 1'b0;
      osig_q   <= '0;
      opix_q   <= '0;
      oline_q  <= '0;
      oprobe_q <= '0;
      ohit_q   <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef RGB_FRAME_MONITOR_COMPARE_EN
      prev_q    <= '0;
      prev_ok_q <= 1'b0;
      chg_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      vs_q     <= vs_d;
      vid_q    <= vid_d;
      sig_q    <= sig_d;
      pix_q    <= pix_d;
      x_q      <= x_d;
      line_q   <= line_d;
      probe_q  <= probe_d;
      hit_q    <= hit_d;
      valid_q  <= valid_d;
      osig_q   <= osig_d;
      opix_q   <= opix_d;
      oline_q  <= oline_d;
      oprobe_q <= oprobe_d;
      ohit_q   <= ohit_d;
      ovr_q    <= ovr_d;
`ifdef RGB_FRAME_MONITOR_COMPARE_EN
      prev_q    <= prev_d;
      prev_ok_q <= prev_ok_d;
      chg_q     <= chg_d;
`endif
    end
  end

  assign pFrameValid = valid_q;
  assign pFrameSig   = osig_q;
  assign pPixelCount = opix_q;
  assign pLineCount  = oline_q;
  assign pProbePixel = oprobe_q;
  assign pProbeHit   = ohit_q;
  assign pOverrun    = ovr_q;
`ifdef RGB_FRAME_MONITOR_COMPARE_EN
  assign pFrameChanged = chg_q;
`endif

endmodule

// File: tb/tb_rgb_frame_monitor.sv
// tb_rgb_frame_monitor: directed checks of rgb_frame_monitor.
// Define RGB_FRAME_MONITOR_COMPARE_EN to also exercise pFrameChanged.
module tb_rgb_frame_monitor;

  logic        pClk = 1'b0;
  logic        pReset;
  logic [3:0]  pRed_VGA, pGreen_VGA, pBlue_VGA;
  logic        pVideo_on;
  logic        pVsync;
  logic [9:0]  pProbeX, pProbeY;
  logic        pFrameAck;
  logic        pFrameValid;
  logic [15:0] pFrameSig;
  logic [19:0] pPixelCount;
  logic [9:0]  pLineCount;
  logic [11:0] pProbePixel;
  logic        pProbeHit;
  logic        pOverrun;
`ifdef RGB_FRAME_MONITOR_COMPARE_EN
  logic        pFrameChanged;
`endif

  int n_run  = 0;
  int n_fail = 0;

  rgb_frame_monitor dut (
    .pClk(pClk), .pReset(pReset),
    .pRed_VGA(pRed_VGA), .pGreen_VGA(pGreen_VGA), .pBlue_VGA(pBlue_VGA),
    .pVideo_on(pVideo_on), .pVsync(pVsync),
    .pProbeX(pProbeX), .pProbeY(pProbeY), .pFrameAck(pFrameAck),
    .pFrameValid(pFrameValid), .pFrameSig(pFrameSig),
    .pPixelCount(pPixelCount), .pLineCount(pLineCount),
    .pProbePixel(pProbePixel), .pProbeHit(pProbeHit),
    .pOverrun(pOverrun)
`ifdef RGB_FRAME_MONITOR_COMPARE_EN
    , .pFrameChanged(pFrameChanged)
`endif
  );

  always #5 pClk = ~pClk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge pClk);
    #1;
  endtask

  task automatic set_pix(input logic [11:0] p);
    {pRed_VGA, pGreen_VGA, pBlue_VGA} = p;
  endtask

  task automatic idle(input int n);
    pVideo_on = 1'b0;
    set_pix(12'h000);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic vsync_pulse();
    pVideo_on = 1'b0;
    pVsync = 1'b0;
    cyc();
    pVsync = 1'b1;
  endtask

  // n pixels: a, b, then a+i for the rest; followed by blanking.
  task automatic send_line(input logic [11:0] a, input logic [11:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      pVideo_on = 1'b1;
      set_pix(i == 0 ? a : (i == 1 ? b : a + 12'(i)));
      cyc();
    end
    idle(2);
  endtask

  task automatic ack_once();
    pFrameAck = 1'b1;
    cyc();
    pFrameAck = 1'b0;
  endtask

  task automatic test_reset();
    pReset = 1'b0;
    pFrameAck = 1'b0;
    pProbeX = '0;
    pProbeY = '0;
    for (int i = 0; i < 6; i++) begin
      pVsync = i[0];
      pVideo_on = ~i[0];
      pFrameAck = i[1];
      set_pix(12'($urandom));
      cyc();
    end
    n_run++;
    if ({pFrameValid, pFrameSig, pPixelCount, pLineCount, pProbePixel, pProbeHit, pOverrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b sig=%h pc=%0d lc=%0d pp=%h ph=%b ov=%b exp all 0",
               pFrameValid, pFrameSig, pPixelCount, pLineCount, pProbePixel, pProbeHit, pOverrun);
    end
    pFrameAck = 1'b0;
    pVsync = 1'b1;
    idle(1);
    pReset = 1'b1;
    idle(3);
    send_line(12'h111, 12'h222, 3);
    vsync_pulse();
    idle(1);
    n_run++;
    if (pFrameValid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_edge_no_commit got valid=%b exp 0", pFrameValid);
    end
  endtask

  task automatic test_basic();
    pProbeX = 10'd1;
    pProbeY = 10'd0;
    idle(2);
    send_line(12'h00F, 12'h0F0, 2);
    pVsync = 1'b0;
    n_run++;
    if (pFrameValid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_valid_before_edge got %b exp 0", pFrameValid);
    end
    cyc();
    pVsync = 1'b1;
    n_run++;
    if (pFrameValid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_valid_rise got %b exp 1", pFrameValid);
    end
    n_run++;
    if (pFrameSig !== 16'h00EE) begin
      n_fail++;
      $display("FAIL basic_sig got %h exp 00ee", pFrameSig);
    end
    n_run++;
    if (pPixelCount !== 20'd2 || pLineCount !== 10'd1) begin
      n_fail++;
      $display("FAIL basic_counts got pc=%0d lc=%0d exp 2 1", pPixelCount, pLineCount);
    end
    n_run++;
    if (pProbePixel !== 12'h0F0 || pProbeHit !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_probe got pp=%h ph=%b exp 0f0 1", pProbePixel, pProbeHit);
    end
`ifdef RGB_FRAME_MONITOR_COMPARE_EN
    n_run++;
    if (pFrameChanged !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_first_changed got %b exp 1", pFrameChanged);
    end
`endif
    ack_once();
    n_run++;
    if (pFrameValid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ack_clear got %b exp 0", pFrameValid);
    end
  endtask

  task automatic test_geometry();
    pProbeX = 10'd9;
    pProbeY = 10'd9;
    for (int l = 0; l < 3; l++) send_line(12'h300, 12'h456, 4);
    vsync_pulse();
    n_run++;
    if (pPixelCount !== 20'd12 || pLineCount !== 10'd3) begin
      n_fail++;
      $display("FAIL geom_counts got pc=%0d lc=%0d exp 12 3", pPixelCount, pLineCount);
    end
    n_run++;
    if (pProbeHit !== 1'b0 || pProbePixel !== 12'h000) begin
      n_fail++;
      $display("FAIL geom_probe_miss got ph=%b pp=%h exp 0 000", pProbeHit, pProbePixel);
    end
    idle(2);
    ack_once();
  endtask

  task automatic test_overrun();
    idle(2);
    send_line(12'h123, 12'h000, 1);
    vsync_pulse();
    idle(2);
    send_line(12'h00F, 12'h0F0, 2);
    vsync_pulse();
    n_run++;
    if (pFrameValid !== 1'b1 || pOverrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_flags got v=%b ov=%b exp 1 1", pFrameValid, pOverrun);
    end
    n_run++;
    if (pFrameSig !== 16'h0123 || pPixelCount !== 20'd1) begin
      n_fail++;
      $display("FAIL ovr_held got sig=%h pc=%0d exp 0123 1", pFrameSig, pPixelCount);
    end
    idle(1);
    ack_once();
    n_run++;
    if (pFrameValid !== 1'b0 || pOverrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_ack_clear got v=%b ov=%b exp 0 0", pFrameValid, pOverrun);
    end
  endtask

  task automatic test_back_to_back();
    pProbeX = 10'd1;
    pProbeY = 10'd0;
    idle(2);
    send_line(12'h100, 12'h200, 3);
    vsync_pulse();
    n_run++;
    if (pFrameValid !== 1'b1 || pPixelCount !== 20'd3) begin
      n_fail++;
      $display("FAIL b2b_first got v=%b pc=%0d exp 1 3", pFrameValid, pPixelCount);
    end
    idle(2);
    send_line(12'h00F, 12'h0F0, 2);
    pFrameAck = 1'b1;
    vsync_pulse();
    pFrameAck = 1'b0;
    n_run++;
    if (pFrameValid !== 1'b1 || pOverrun !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_flags got v=%b ov=%b exp 1 0", pFrameValid, pOverrun);
    end
    n_run++;
    if (pFrameSig !== 16'h00EE || pPixelCount !== 20'd2 || pProbePixel !== 12'h0F0) begin
      n_fail++;
      $display("FAIL b2b_values got sig=%h pc=%0d pp=%h exp 00ee 2 0f0", pFrameSig, pPixelCount, pProbePixel);
    end
    idle(1);
    ack_once();
    n_run++;
    if (pFrameValid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ack_clear got %b exp 0", pFrameValid);
    end
  endtask

`ifdef RGB_FRAME_MONITOR_COMPARE_EN
  task automatic test_compare();
    logic [11:0] second [3];
    logic        exp    [3];
    second = '{12'h055, 12'h055, 12'h056};
    exp    = '{1'b1, 1'b0, 1'b1};
    for (int f = 0; f < 3; f++) begin
      idle(2);
      send_line(12'h0AA, second[f], 2);
      vsync_pulse();
      n_run++;
      if (pFrameChanged !== exp[f]) begin
        n_fail++;
        $display("FAIL compare_frame%0d got %b exp %b", f, pFrameChanged, exp[f]);
      end
      idle(1);
      ack_once();
    end
  endtask
`endif

  initial begin
    pReset = 1'b0;
    pVsync = 1'b1;
    pVideo_on = 1'b0;
    pFrameAck = 1'b0;
    pProbeX = '0;
    pProbeY = '0;
    set_pix(12'h000);
    test_reset();
    test_basic();
    test_geometry();
    test_overrun();
    test_back_to_back();
`ifdef RGB_FRAME_MONITOR_COMPARE_EN
    test_compare();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
